// File: rtl/fp_pkg.sv
// Shared constants, types and helpers for the floating-point classify/round stage.
package fp_pkg;

  // Wide all-ones constant; modules slice it down to their exponent width.
  localparam logic [63:0] EXP_ALL_ONES = '1;

  localparam int E4M3_EXPONENT_WIDTH = 4;
  localparam int E4M3_MANTISSA_WIDTH = 3;

  typedef struct packed {
    logic zero;
    logic infinite;
    logic signaling_nan;
    logic quiet_nan;
  } fp_class_t;

  function automatic bit fp_is_e4m3(int ew, int mw);
    return (ew == E4M3_EXPONENT_WIDTH) && (mw == E4M3_MANTISSA_WIDTH);
  endfunction

endpackage

// File: rtl/fp_classify_round_stage_if.sv
// Operand/result bundle between the multiply/add core and the classify/round stage.
interface fp_classify_round_stage_if #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int ROUNDING_BITS  = MANTISSA_WIDTH + 1
);
  logic                                  in_valid;
  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] a;
  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] b;
  logic [EXPONENT_WIDTH-1:0]             non_rounded_exponent;
  logic [MANTISSA_WIDTH-1:0]             non_rounded_mantissa;
  logic [ROUNDING_BITS-1:0]              rounding_bits;

  logic                                  out_valid;
  logic                                  a_is_zero;
  logic                                  a_is_infinite;
  logic                                  a_is_signaling_nan;
  logic                                  a_is_quiet_nan;
  logic                                  b_is_zero;
  logic                                  b_is_infinite;
  logic                                  b_is_signaling_nan;
  logic                                  b_is_quiet_nan;
  logic [EXPONENT_WIDTH-1:0]             rounded_exponent;
  logic [MANTISSA_WIDTH-1:0]             rounded_mantissa;
  logic                                  overflow_flag;
  logic                                  inexact_flag;

  modport master (
    output in_valid, a, b, non_rounded_exponent, non_rounded_mantissa, rounding_bits,
    input  out_valid, a_is_zero, a_is_infinite, a_is_signaling_nan, a_is_quiet_nan,
           b_is_zero, b_is_infinite, b_is_signaling_nan, b_is_quiet_nan,
           rounded_exponent, rounded_mantissa, overflow_flag, inexact_flag
  );

  modport slave (
    input  in_valid, a, b, non_rounded_exponent, non_rounded_mantissa, rounding_bits,
    output out_valid, a_is_zero, a_is_infinite, a_is_signaling_nan, a_is_quiet_nan,
           b_is_zero, b_is_infinite, b_is_signaling_nan, b_is_quiet_nan,
           rounded_exponent, rounded_mantissa, overflow_flag, inexact_flag
  );
endinterface

// File: rtl/fp_special_classifier.sv
// Combinational zero/inf/sNaN/qNaN detection for one operand (sign not needed).
module fp_special_classifier
  import fp_pkg::*;
#(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23
) (
  input  logic [EXPONENT_WIDTH-1:0] exp_i,
  input  logic [MANTISSA_WIDTH-1:0] frac_i,
  output fp_class_t                 class_o
);

  localparam bit IS_E4M3 = fp_is_e4m3(EXPONENT_WIDTH, MANTISSA_WIDTH);
  localparam logic [EXPONENT_WIDTH-1:0] EXP_ONES = EXP_ALL_ONES[EXPONENT_WIDTH-1:0];

  logic exp_max;
  logic exp_zero;
  logic frac_zero;

  assign exp_max   = (exp_i == EXP_ONES);
  assign exp_zero  = (exp_i == '0);
  assign frac_zero = (frac_i == '0);

  always_comb begin
    class_o      = '0;
    class_o.zero = exp_zero && frac_zero;
    if (IS_E4M3) begin
      // E4M3 has no infinities; only the single all-ones pattern is NaN.
      class_o.quiet_nan = exp_max && (&frac_i);
    end else begin
      class_o.infinite      = exp_max && frac_zero;
      class_o.quiet_nan     = exp_max && frac_i[MANTISSA_WIDTH-1];
      class_o.signaling_nan = exp_max && !frac_i[MANTISSA_WIDTH-1] && !frac_zero;
    end
  end

endmodule

// File: rtl/fp_classify_round_stage.sv
// Registered stage: classifies operands A/B and rounds the unrounded result.
module fp_classify_round_stage
  import fp_pkg::*;
#(
  parameter int EXPONENT_WIDTH   = 8,
  parameter int MANTISSA_WIDTH   = 23,
  parameter int ROUND_TO_NEAREST = 1,
  parameter int ROUNDING_BITS    = MANTISSA_WIDTH + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  fp_classify_round_stage_if.slave bus
);

  localparam int SIGN_BIT = EXPONENT_WIDTH + MANTISSA_WIDTH;
  localparam logic [EXPONENT_WIDTH-1:0] EXP_ONES = EXP_ALL_ONES[EXPONENT_WIDTH-1:0];

  fp_class_t a_class_d, b_class_d;
  fp_class_t a_class_q, b_class_q;

  fp_special_classifier #(
    .EXPONENT_WIDTH(EXPONENT_WIDTH),
    .MANTISSA_WIDTH(MANTISSA_WIDTH)
  ) u_class_a (
    .exp_i  (bus.a[SIGN_BIT-1:MANTISSA_WIDTH]),
    .frac_i (bus.a[MANTISSA_WIDTH-1:0]),
    .class_o(a_class_d)
  );

  fp_special_classifier #(
    .EXPONENT_WIDTH(EXPONENT_WIDTH),
    .MANTISSA_WIDTH(MANTISSA_WIDTH)
  ) u_class_b (
    .exp_i  (bus.b[SIGN_BIT-1:MANTISSA_WIDTH]),
    .frac_i (bus.b[MANTISSA_WIDTH-1:0]),
    .class_o(b_class_d)
  );

  logic                      guard;
  logic                      sticky;
  logic                      round_up;
  logic                      carry;
  logic [MANTISSA_WIDTH-1:0] mant_sum;
  logic [EXPONENT_WIDTH-1:0] exp_sum;
  logic [EXPONENT_WIDTH-1:0] exp_d,   exp_q;
  logic [MANTISSA_WIDTH-1:0] mant_d,  mant_q;
  logic                      ovf_d,   ovf_q;
  logic                      inexact_d, inexact_q;
  logic                      out_valid_q;

  always_comb begin
    guard     = bus.rounding_bits[ROUNDING_BITS-1];
    sticky    = |bus.rounding_bits[ROUNDING_BITS-2:0];
    inexact_d = guard || sticky;
    round_up  = (ROUND_TO_NEAREST != 0) && guard && (sticky || bus.non_rounded_mantissa[0]);
    {carry, mant_sum} = {1'b0, bus.non_rounded_mantissa} + {{MANTISSA_WIDTH{1'b0}}, round_up};
    exp_sum   = bus.non_rounded_exponent + {{(EXPONENT_WIDTH-1){1'b0}}, carry};

    exp_d  = exp_sum;
    mant_d = mant_sum;
    ovf_d  = 1'b0;
    if (bus.non_rounded_exponent == EXP_ONES) begin
      // Already saturated: hold the exponent, flag only a fresh carry.
      exp_d = EXP_ONES;
      ovf_d = carry;
    end else if (carry && (exp_sum == EXP_ONES)) begin
      exp_d  = EXP_ONES;
      mant_d = '0;
      ovf_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      a_class_q   <= '0;
      b_class_q   <= '0;
      exp_q       <= '0;
      mant_q      <= '0;
      ovf_q       <= 1'b0;
      inexact_q   <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        a_class_q <= a_class_d;
        b_class_q <= b_class_d;
        exp_q     <= exp_d;
        mant_q    <= mant_d;
        ovf_q     <= ovf_d;
        inexact_q <= inexact_d;
      end
    end
  end

  assign bus.out_valid          = out_valid_q;
  assign bus.a_is_zero          = a_class_q.zero;
  assign bus.a_is_infinite      = a_class_q.infinite;
  assign bus.a_is_signaling_nan = a_class_q.signaling_nan;
  assign bus.a_is_quiet_nan     = a_class_q.quiet_nan;
  assign bus.b_is_zero          = b_class_q.zero;
  assign bus.b_is_infinite      = b_class_q.infinite;
  assign bus.b_is_signaling_nan = b_class_q.signaling_nan;
  assign bus.b_is_quiet_nan     = b_class_q.quiet_nan;
  assign bus.rounded_exponent   = exp_q;
  assign bus.rounded_mantissa   = mant_q;
  assign bus.overflow_flag      = ovf_q;
  assign bus.inexact_flag       = inexact_q;

endmodule

// File: tb/tb_fp_classify_round_stage.sv
// Scoreboard bench: FP32 round-to-nearest, FP32 truncate and E4M3 instances.
module tb_fp_classify_round_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_classify_round_stage_if #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .ROUNDING_BITS(24)) bus32();
  fp_classify_round_stage_if #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .ROUNDING_BITS(24)) bustr();
  fp_classify_round_stage_if #(.EXPONENT_WIDTH(4), .MANTISSA_WIDTH(3),  .ROUNDING_BITS(4))  bus43();

  fp_classify_round_stage #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .ROUND_TO_NEAREST(1), .ROUNDING_BITS(24))
    u_fp32 (.clk(clk), .rst(rst), .bus(bus32.slave));
  fp_classify_round_stage #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .ROUND_TO_NEAREST(0), .ROUNDING_BITS(24))
    u_trunc (.clk(clk), .rst(rst), .bus(bustr.slave));
  fp_classify_round_stage #(.EXPONENT_WIDTH(4), .MANTISSA_WIDTH(3), .ROUND_TO_NEAREST(1), .ROUNDING_BITS(4))
    u_e4m3 (.clk(clk), .rst(rst), .bus(bus43.slave));

  // Result vector: {az, ai, as, aq, bz, bi, bs, bq, exp[31:0], mant[31:0], ovf, inexact}
  logic [73:0] act32, acttr, act43;
  assign act32 = {bus32.a_is_zero, bus32.a_is_infinite, bus32.a_is_signaling_nan, bus32.a_is_quiet_nan,
                  bus32.b_is_zero, bus32.b_is_infinite, bus32.b_is_signaling_nan, bus32.b_is_quiet_nan,
                  32'(bus32.rounded_exponent), 32'(bus32.rounded_mantissa),
                  bus32.overflow_flag, bus32.inexact_flag};
  assign acttr = {bustr.a_is_zero, bustr.a_is_infinite, bustr.a_is_signaling_nan, bustr.a_is_quiet_nan,
                  bustr.b_is_zero, bustr.b_is_infinite, bustr.b_is_signaling_nan, bustr.b_is_quiet_nan,
                  32'(bustr.rounded_exponent), 32'(bustr.rounded_mantissa),
                  bustr.overflow_flag, bustr.inexact_flag};
  assign act43 = {bus43.a_is_zero, bus43.a_is_infinite, bus43.a_is_signaling_nan, bus43.a_is_quiet_nan,
                  bus43.b_is_zero, bus43.b_is_infinite, bus43.b_is_signaling_nan, bus43.b_is_quiet_nan,
                  32'(bus43.rounded_exponent), 32'(bus43.rounded_mantissa),
                  bus43.overflow_flag, bus43.inexact_flag};

  logic [73:0] q32[$];
  logic [73:0] qtr[$];
  logic [73:0] q43[$];

  logic        chk_idle = 1'b0;
  logic [73:0] idle_exp = '0;
  logic        done     = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [73:0] pack(logic [7:0] flags, logic [31:0] e, logic [31:0] m,
                                       logic ovf, logic inx);
    return {flags, e, m, ovf, inx};
  endfunction

  function automatic void cmp(string name, logic [73:0] act, logic [73:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got flags=%b exp=%h mant=%h ovf=%b inx=%b, want flags=%b exp=%h mant=%h ovf=%b inx=%b",
               name, act[73:66], act[65:34], act[33:2], act[1], act[0],
               exp[73:66], exp[65:34], exp[33:2], exp[1], exp[0]);
    end
  endfunction

  // Monitor: pops the scoreboard whenever an instance presents a result.
  always @(negedge clk) begin
    if (bus32.out_valid) begin
      if (q32.size() == 0) begin n_checks++; n_fail++; $display("FAIL fp32_unexpected: got out_valid=1, want no output"); end
      else cmp("fp32_result", act32, q32.pop_front());
    end
    if (bustr.out_valid) begin
      if (qtr.size() == 0) begin n_checks++; n_fail++; $display("FAIL trunc_unexpected: got out_valid=1, want no output"); end
      else cmp("trunc_result", acttr, qtr.pop_front());
    end
    if (bus43.out_valid) begin
      if (q43.size() == 0) begin n_checks++; n_fail++; $display("FAIL e4m3_unexpected: got out_valid=1, want no output"); end
      else cmp("e4m3_result", act43, q43.pop_front());
    end
    if (chk_idle) begin
      n_checks++;
      if (bus32.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL fp32_idle_valid: got out_valid=%b, want 0", bus32.out_valid);
      end
      cmp("fp32_idle_data", act32, idle_exp);
    end
    if (done) begin
      n_checks++;
      if (q32.size() + qtr.size() + q43.size() != 0) begin
        n_fail++;
        $display("FAIL drain: got %0d results outstanding, want 0", q32.size() + qtr.size() + q43.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  task automatic drive32(logic [31:0] a, logic [31:0] b, logic [7:0] e, logic [22:0] m, logic [23:0] rb,
                         logic [73:0] expv);
    bus32.a = a; bus32.b = b; bus32.non_rounded_exponent = e;
    bus32.non_rounded_mantissa = m; bus32.rounding_bits = rb; bus32.in_valid = 1'b1;
    q32.push_back(expv);
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
  endtask

  task automatic drivetr(logic [31:0] a, logic [31:0] b, logic [7:0] e, logic [22:0] m, logic [23:0] rb,
                         logic [73:0] expv);
    bustr.a = a; bustr.b = b; bustr.non_rounded_exponent = e;
    bustr.non_rounded_mantissa = m; bustr.rounding_bits = rb; bustr.in_valid = 1'b1;
    qtr.push_back(expv);
    @(posedge clk); #1;
    bustr.in_valid = 1'b0;
  endtask

  task automatic drive43(logic [7:0] a, logic [7:0] b, logic [3:0] e, logic [2:0] m, logic [3:0] rb,
                         logic [73:0] expv);
    bus43.a = a; bus43.b = b; bus43.non_rounded_exponent = e;
    bus43.non_rounded_mantissa = m; bus43.rounding_bits = rb; bus43.in_valid = 1'b1;
    q43.push_back(expv);
    @(posedge clk); #1;
    bus43.in_valid = 1'b0;
  endtask

  task automatic idle_check(logic [73:0] expv);
    idle_exp = expv;
    chk_idle = 1'b1;
    @(negedge clk); #1;
    chk_idle = 1'b0;
  endtask

  initial begin
    bus32.in_valid = 0; bus32.a = '0; bus32.b = '0; bus32.non_rounded_exponent = '0;
    bus32.non_rounded_mantissa = '0; bus32.rounding_bits = '0;
    bustr.in_valid = 0; bustr.a = '0; bustr.b = '0; bustr.non_rounded_exponent = '0;
    bustr.non_rounded_mantissa = '0; bustr.rounding_bits = '0;
    bus43.in_valid = 0; bus43.a = '0; bus43.b = '0; bus43.non_rounded_exponent = '0;
    bus43.non_rounded_mantissa = '0; bus43.rounding_bits = '0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle_check('0);

    // FP32 round-to-nearest-even
    drive32(32'h7F800000, 32'h7FC00000, 8'h00, 23'h000000, 24'h000000, pack(8'b0100_0001, 32'h00, 32'h000000, 0, 0));
    drive32(32'h7F800001, 32'h80000000, 8'h00, 23'h000000, 24'h000000, pack(8'b0010_1000, 32'h00, 32'h000000, 0, 0));
    drive32(32'h3F800000, 32'h00000001, 8'h7F, 23'h000000, 24'h800000, pack(8'b0000_0000, 32'h7F, 32'h000000, 0, 1));
    drive32(32'h3F800000, 32'h00000001, 8'h7F, 23'h000001, 24'h800000, pack(8'b0000_0000, 32'h7F, 32'h000002, 0, 1));
    drive32(32'hFF800000, 32'hFFBFFFFF, 8'h80, 23'h7FFFFF, 24'hC00000, pack(8'b0100_0010, 32'h81, 32'h000000, 0, 1));
    drive32(32'hFFC00001, 32'h7F7FFFFF, 8'hFE, 23'h7FFFFF, 24'h800001, pack(8'b0001_0000, 32'hFF, 32'h000000, 1, 1));
    drive32(32'h00000000, 32'h00400000, 8'hFF, 23'h7FFFFF, 24'hC00000, pack(8'b1000_0000, 32'hFF, 32'h000000, 1, 1));
    drive32(32'h3F800000, 32'h3F800000, 8'h01, 23'h000003, 24'h000001, pack(8'b0000_0000, 32'h01, 32'h000003, 0, 1));
    drive32(32'h3F800000, 32'h3F800000, 8'h10, 23'h000005, 24'h800002, pack(8'b0000_0000, 32'h10, 32'h000006, 0, 1));
    drive32(32'h3F800000, 32'h3F800000, 8'h22, 23'h0ABCDE, 24'h000000, pack(8'b0000_0000, 32'h22, 32'h0ABCDE, 0, 0));
    drive32(32'h3F800000, 32'h3F800000, 8'h7E, 23'h000004, 24'h7FFFFF, pack(8'b0000_0000, 32'h7E, 32'h000004, 0, 1));

    // Without in_valid the outputs hold the last captured result.
    bus32.a = 32'h7F800000; bus32.non_rounded_exponent = 8'hFE;
    bus32.non_rounded_mantissa = 23'h7FFFFF; bus32.rounding_bits = 24'hFFFFFF;
    @(posedge clk); #1;
    idle_check(pack(8'b0000_0000, 32'h7E, 32'h000004, 0, 1));

    // Reset wins over a simultaneous in_valid.
    bus32.in_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0; rst = 1'b0;
    idle_check('0);

    // FP32 truncation
    drivetr(32'h7F800000, 32'h00000000, 8'h10, 23'h123456, 24'hFFFFFF, pack(8'b0100_1000, 32'h10, 32'h123456, 0, 1));
    drivetr(32'h3F800000, 32'h3F800000, 8'h80, 23'h7FFFFF, 24'hC00000, pack(8'b0000_0000, 32'h80, 32'h7FFFFF, 0, 1));
    drivetr(32'h3F800000, 32'h3F800000, 8'h20, 23'h000001, 24'h000000, pack(8'b0000_0000, 32'h20, 32'h000001, 0, 0));

    // E4M3
    drive43(8'h7F, 8'h78, 4'h0, 3'h0, 4'h0, pack(8'b0001_0000, 32'h0, 32'h0, 0, 0));
    drive43(8'h78, 8'hFF, 4'h0, 3'h0, 4'h0, pack(8'b0000_0001, 32'h0, 32'h0, 0, 0));
    drive43(8'h80, 8'h79, 4'h0, 3'h0, 4'h0, pack(8'b1000_0000, 32'h0, 32'h0, 0, 0));
    drive43(8'h00, 8'h00, 4'hE, 3'h7, 4'h9, pack(8'b1000_1000, 32'hF, 32'h0, 1, 1));
    drive43(8'h38, 8'h38, 4'h3, 3'h2, 4'h8, pack(8'b0000_0000, 32'h3, 32'h2, 0, 1));
    drive43(8'h38, 8'h38, 4'h3, 3'h3, 4'h8, pack(8'b0000_0000, 32'h3, 32'h4, 0, 1));
    drive43(8'h38, 8'h38, 4'h3, 3'h7, 4'hC, pack(8'b0000_0000, 32'h4, 32'h0, 0, 1));

    repeat (3) @(posedge clk);
    #1 done = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end of test, want end within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fp_classify_round_stage.md
Name: fp_classify_round_stage

Overview:
- Registered single-stage helper for the floating-point arithmetic datapath.
- Classifies two packed operands as zero, infinity, signaling NaN or quiet NaN.
- Rounds an unrounded result (exponent, mantissa, extra low-order bits) to the target format.
- Sits between the raw multiply/add core and the output packer, with a one-cycle valid pipeline.

Parameters:
- EXPONENT_WIDTH, 8: exponent field width.
- MANTISSA_WIDTH, 23: stored fraction width, excluding the hidden bit.
- ROUND_TO_NEAREST, 1: 1 = round-to-nearest-even; 0 = round toward zero (truncate).
- ROUNDING_BITS, MANTISSA_WIDTH+1: width of the discarded low-order bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample qualifier.
- a  in  1+EXPONENT_WIDTH+MANTISSA_WIDTH  operand A, packed {sign, exponent, fraction}.
- b  in  1+EXPONENT_WIDTH+MANTISSA_WIDTH  operand B, same packing.
- non_rounded_exponent  in  EXPONENT_WIDTH  biased exponent before rounding.
- non_rounded_mantissa  in  MANTISSA_WIDTH  fraction before rounding.
- rounding_bits  in  ROUNDING_BITS  discarded bits; MSB is the guard bit.
- out_valid  out  1  registered in_valid.
- a_is_zero, a_is_infinite, a_is_signaling_nan, a_is_quiet_nan  out  1 each  classification of A.
- b_is_zero, b_is_infinite, b_is_signaling_nan, b_is_quiet_nan  out  1 each  classification of B.
- rounded_exponent  out  EXPONENT_WIDTH  exponent after rounding.
- rounded_mantissa  out  MANTISSA_WIDTH  fraction after rounding.
- overflow_flag  out  1  rounding carried the exponent to all-ones.
- inexact_flag  out  1  any rounding bit was nonzero.

Behaviour:
- Latency and capture:
  - One cycle latency.
  - When in_valid=1 at a rising edge, all outputs update with results computed from that edge's inputs, and out_valid=1.
  - When in_valid=0, out_valid=0 and the data outputs hold their previous values.
  - No backpressure.
- Reset:
  - rst=1 at an edge clears every output to 0, including out_valid.
  - rst has priority over a simultaneous in_valid.
- Classification (per operand; E = exponent field, F = fraction field):
  - zero: E==0 and F==0. Sign is ignored.
  - infinite: E all-ones and F==0.
  - quiet NaN: E all-ones and F MSB=1.
  - signaling NaN: E all-ones, F MSB=0, F!=0.
  - Subnormals (E==0, F!=0) assert no flag.
  - E4M3 exception (EXPONENT_WIDTH=4, MANTISSA_WIDTH=3):
    - No infinities; infinite is always 0.
    - Only E=1111 with F=111 is NaN, reported as quiet.
    - Other E=1111 encodings are normal numbers.
  - At most one flag per operand is set.
- Rounding:
  - guard = rounding_bits MSB; sticky = OR of the remaining rounding bits.
  - inexact_flag = guard | sticky.
  - ROUND_TO_NEAREST=1: round up when guard & (sticky | non_rounded_mantissa[0]). Ties go to even.
  - ROUND_TO_NEAREST=0: never round up.
  - Round-up adds 1 to the mantissa. On carry-out: mantissa becomes 0 and exponent is incremented.
  - If the resulting exponent is all-ones: overflow_flag=1, rounded_exponent=all-ones, rounded_mantissa=0.
  - Otherwise overflow_flag=0 and the incremented values are output as computed.
  - Input exponent already all-ones: pass it through unchanged. Set overflow_flag=1 only if rounding carries.
  - Inputs are treated as unsigned; no sign handling is done in this block.

Decomposition:
- Shared package fp_pkg:
  - Localparams for the all-ones exponent and the E4M3 detection predicate.
  - Function fp_is_e4m3(ew, mw).
- One natural sub-module: fp_special_classifier (combinational classification of one operand), instantiated for A and B.
- Rounding logic and output registers stay in the top module.

Test Plan:
- Classification, FP32:
  - a=0x7F800000, b=0x7FC00000 -> a_is_infinite=1, b_is_quiet_nan=1, all other flags 0.
  - a=0x7F800001, b=0x80000000 -> a_is_signaling_nan=1, b_is_zero=1.
- Tie to even, FP32:
  - exp=0x7F, mant=0x000000, bits=0x800000 -> mant=0x000000, inexact=1.
  - mant=0x000001 with the same bits -> mant=0x000002.
- Mantissa carry: exp=0x80, mant=0x7FFFFF, bits=0xC00000 -> exp=0x81, mant=0, overflow=0.
- Exponent overflow: exp=0xFE, mant=0x7FFFFF, bits=0x800001 -> exp=0xFF, mant=0, overflow=1, inexact=1.
- Truncation mode (ROUND_TO_NEAREST=0): exp=0x10, mant=0x123456, bits=0xFFFFFF -> exp=0x10, mant=0x123456, inexact=1.
- E4M3 and reset:
  - a=0x7F -> a_is_quiet_nan=1.
  - a=0x78 -> no flags.
  - rst=1 together with in_valid=1 -> next cycle out_valid=0 and all outputs 0.
